seg_scan_ctrl: RTL

Scan controller and scheduler for the 4-digit multiplexed seven-segment display. It time-slices the shared decoder and segment bus across 4 digits, with an anti-ghosting blank interval and per-digit brightness PWM. It takes display updates through a valid/ready handshake and commits them only at frame boundaries, so a digit never tears mid-frame. Its outputs feed sev_seg_dec (nibble) and the seg_sel pins; it replaces ad-hoc scan counters in top levels.

---
 rtl/seg_scan_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: blanking, brightness PWM, frame-synchronous updates.
// Optional leading-zero suppression is enabled by defining SEG_LZS_EN.
module seg_scan_ctrl #(
  parameter int CLK_FREQ  = 200_000_000,
  parameter int DIGIT_HZ  = 1000,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  bright,
  output logic [3:0]  seg_sel,
  output logic [3:0]  nibble,
  output logic        dp,
  output logic        frame_tick
);

  localparam int DIG_CYC = CLK_FREQ / DIGIT_HZ;
  localparam int DRV_CYC = DIG_CYC - BLANK_CYC;
  localparam int ON_UNIT = DRV_CYC / 16;
  localparam int CW      = $clog2(DIG_CYC);

  if (DIG_CYC < BLANK_CYC + 16) begin : g_bad_cfg
    $error("seg_scan_ctrl: DIG_CYC must be >= BLANK_CYC+16");
  end

  logic [CW-1:0] cnt_q;
  logic [1:0]    slot_q;
  logic [3:0]    bright_q;
  logic [15:0]   act_q, pend_q;
  logic [3:0]    actdp_q, penddp_q;
  logic          pflag_q, pflag_d;
  logic          ready_q;
  logic [3:0]    seg_sel_q;
  logic [3:0]    nibble_q;
  logic          dp_q;
  logic          tick_q;

  logic       last_cnt, frame_end, xfer, strobe;
  logic [3:0] bright_c, supp, en_eff, cur_nib;
  int         offs;

  assign last_cnt  = cnt_q == CW'(DIG_CYC - 1);
  assign frame_end = last_cnt && (slot_q == 2'd3);
  assign xfer      = load_valid && ready_q;

  // The slot-start sample is used directly so cnt==0 already sees the new level.
  assign bright_c = (cnt_q == '0) ? bright : bright_q;
  assign offs     = int'(cnt_q) - BLANK_CYC;
  assign strobe   = (offs >= 0) &&
                    ((bright_c == 4'hF) ||
                     (offs < ON_UNIT * (int'(bright_c) + 1)));

`ifdef SEG_LZS_EN
  assign supp[0] = act_q[15:12] == 4'h0;
  assign supp[1] = supp[0] && (act_q[11:8] == 4'h0);
  assign supp[2] = supp[1] && (act_q[7:4] == 4'h0);
  assign supp[3] = 1'b0;
`else
  assign supp = 4'h0;
`endif

  assign en_eff = digit_en & ~supp;

  always_comb begin
    cur_nib = act_q[15:12];
    unique case (slot_q)
      2'd0: cur_nib = act_q[15:12];
      2'd1: cur_nib = act_q[11:8];
      2'd2: cur_nib = act_q[7:4];
      2'd3: cur_nib = act_q[3:0];
    endcase
  end

  always_comb begin
    pflag_d = pflag_q;
    if (frame_end && pflag_q)
      pflag_d = 1'b0;
    else if (xfer)
      pflag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      slot_q    <= 2'd0;
      bright_q  <= 4'h0;
      act_q     <= 16'h0;
      actdp_q   <= 4'h0;
      pend_q    <= 16'h0;
      penddp_q  <= 4'h0;
      pflag_q   <= 1'b0;
      ready_q   <= 1'b0;
      seg_sel_q <= 4'h0;
      nibble_q  <= 4'h0;
      dp_q      <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q <= last_cnt ? '0 : cnt_q + CW'(1);
      if (last_cnt)
        slot_q <= slot_q + 2'd1;
      if (cnt_q == '0)
        bright_q <= bright;
      if (xfer) begin
        pend_q   <= load_data;
        penddp_q <= load_dp;
      end
      if (frame_end && pflag_q) begin
        act_q   <= pend_q;
        actdp_q <= penddp_q;
      end
      pflag_q   <= pflag_d;
      ready_q   <= !pflag_d;
      seg_sel_q <= (strobe && en_eff[slot_q]) ? (4'b0001 << slot_q) : 4'h0;
      nibble_q  <= cur_nib;
      dp_q      <= actdp_q[slot_q] && !supp[slot_q];
      tick_q    <= frame_end;
    end
  end

  assign load_ready = ready_q;
  assign seg_sel    = seg_sel_q;
  assign nibble     = nibble_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule
